even_odd_sweep_ctrl: RTL and testbench

Sequencer that sweeps an inclusive value range [lo, hi] through the even_odd classifier, one value per clock. It tallies how many values are even and how many are odd, and reports completion with a one-cycle done pulse. It is the self-running, synthesizable replacement for hand-written stimulus sequences driving even_odd, and the top-level controller for classification sweeps.

---
 rtl/even_odd_pkg.sv | 12 +
 rtl/even_odd.sv | 15 +
 rtl/even_odd_sweep_ctrl.sv | 107 ++++++++++
 tb/tb_even_odd_sweep_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/even_odd_pkg.sv
// Shared types and defaults for the even_odd classifier and its sweep controller.
package even_odd_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/even_odd.sv
// Parity classifier: flags a value as even or odd from its least significant bit.
module even_odd
    import even_odd_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    output logic             even,
    output logic             odd
);

    assign even = ~a[0];
    assign odd  = a[0];

endmodule

// File: rtl/even_odd_sweep_ctrl.sv
// Sweeps an inclusive range [lo, hi] through even_odd one value per clock,
// tallying even/odd results and pulsing done when the range is exhausted.
module even_odd_sweep_ctrl
    import even_odd_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic             pause,
    output logic             busy,
    output logic [WIDTH-1:0] cur_val,
    output logic             cur_valid,
    output logic             cur_even,
    output logic             cur_odd,
    output logic [WIDTH-1:0] even_cnt,
    output logic [WIDTH-1:0] odd_cnt,
    output logic             done,
    output logic             err
);

    localparam int unsigned CNT_W = WIDTH;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   cur_q, cur_d;
    logic [CNT_W-1:0]   even_q, even_d;
    logic [CNT_W-1:0]   odd_q, odd_d;
    logic               err_q, err_d;
    logic               valid;

    even_odd #(.WIDTH(WIDTH)) u_even_odd (
        .a    (cur_q),
        .even (cur_even),
        .odd  (cur_odd)
    );

    assign valid = (state_q == ST_SCAN) && !pause;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hi_q    <= '0;
            cur_q   <= '0;
            even_q  <= '0;
            odd_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            cur_q   <= cur_d;
            even_q  <= even_d;
            odd_q   <= odd_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        cur_d   = cur_q;
        even_d  = even_q;
        odd_d   = odd_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (lo <= hi) begin
                        hi_d    = hi;
                        cur_d   = lo;
                        even_d  = '0;
                        odd_d   = '0;
                        state_d = ST_SCAN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_SCAN: begin
                if (valid) begin
                    even_d = even_q + CNT_W'(cur_even);
                    odd_d  = odd_q + CNT_W'(cur_odd);
                    // End test precedes the increment so hi = all-ones never wraps.
                    if (cur_q == hi_q) begin
                        state_d = ST_DONE;
                    end else begin
                        cur_d = cur_q + WIDTH'(1);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;
    assign cur_val   = cur_q;
    assign cur_valid = valid;
    assign even_cnt  = even_q;
    assign odd_cnt   = odd_q;

endmodule

// File: tb/tb_even_odd_sweep_ctrl.sv
// Self-checking bench for even_odd_sweep_ctrl: table-driven sweeps, random sweeps,
// and a mid-sweep reset, all checked against a queue-based range model.
module tb_even_odd_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] lo = '0;
    logic [3:0] hi = '0;
    logic       pause = 1'b0;
    logic       busy, cur_valid, cur_even, cur_odd, done, err;
    logic [3:0] cur_val, even_cnt, odd_cnt;

    int checks = 0;
    int errors = 0;
    int m_even = 0;
    int m_odd = 0;

    even_odd_sweep_ctrl #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .lo        (lo),
        .hi        (hi),
        .pause     (pause),
        .busy      (busy),
        .cur_val   (cur_val),
        .cur_valid (cur_valid),
        .cur_even  (cur_even),
        .cur_odd   (cur_odd),
        .even_cnt  (even_cnt),
        .odd_cnt   (odd_cnt),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int lo_v;
        int hi_v;
        int pmode;
        int exp_e;
        int exp_o;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // pmode: 0 no pause, 1 three-cycle pause mid-sweep, 2 random pauses.
    task automatic run_sweep(input int lo_v, input int hi_v, input int pmode,
                             input int tab_e, input int tab_o, input bit use_tab);
        int q[$];
        int p;
        int cyc;
        int v;
        @(negedge clk);
        lo = 4'(lo_v);
        hi = 4'(hi_v);
        start = 1'b1;
        #1;
        chk("idle_busy", busy, 0);
        @(negedge clk);
        start = 1'b0;
        if (lo_v > hi_v) begin
            #1;
            chk("err_pulse", err, 1);
            chk("err_busy", busy, 0);
            chk("err_even_hold", even_cnt, m_even);
            chk("err_odd_hold", odd_cnt, m_odd);
            @(negedge clk);
            #1;
            chk("err_once", err, 0);
            chk("err_no_done", done, 0);
            chk("err_busy2", busy, 0);
        end else begin
            for (int i = lo_v; i <= hi_v; i++) q.push_back(i);
            m_even = 0;
            m_odd = 0;
            p = 0;
            cyc = 1;
            while (q.size() > 0 && cyc < 200) begin
                case (pmode)
                    1: pause = (cyc >= 5 && cyc < 8);
                    2: pause = ($urandom_range(0, 3) == 0);
                    default: pause = 1'b0;
                endcase
                start = 1'($urandom_range(0, 1));
                lo = 4'($urandom_range(0, 15));
                hi = 4'($urandom_range(0, 15));
                #1;
                chk("scan_busy", busy, 1);
                chk("scan_no_done", done, 0);
                v = q[0];
                chk("scan_cur_val", cur_val, v);
                if (pause) begin
                    chk("pause_valid", cur_valid, 0);
                    p++;
                end else begin
                    chk("scan_valid", cur_valid, 1);
                    chk("cur_even", cur_even, (v % 2 == 0) ? 1 : 0);
                    chk("cur_odd", cur_odd, (v % 2 == 1) ? 1 : 0);
                    if (v % 2 == 0) m_even++;
                    else m_odd++;
                    void'(q.pop_front());
                end
                @(negedge clk);
                cyc++;
            end
            chk("sweep_timeout", q.size(), 0);
            pause = 1'b0;
            start = 1'b0;
            #1;
            chk("done_pulse", done, 1);
            chk("done_latency", cyc, 2 + (hi_v - lo_v) + p);
            chk("done_even", even_cnt, m_even);
            chk("done_odd", odd_cnt, m_odd);
            chk("done_sum", int'(even_cnt) + int'(odd_cnt), hi_v - lo_v + 1);
            chk("done_cur_val", cur_val, hi_v);
            if (use_tab) begin
                chk("table_even", even_cnt, tab_e);
                chk("table_odd", odd_cnt, tab_o);
            end
            @(negedge clk);
            #1;
            chk("post_done_low", done, 0);
            chk("post_busy_low", busy, 0);
            chk("post_even_hold", even_cnt, m_even);
            chk("post_odd_hold", odd_cnt, m_odd);
        end
    endtask

    vec_t tab[6];
    int   guard;

    initial begin
        tab[0] = '{lo_v: 0,  hi_v: 10, pmode: 0, exp_e: 6, exp_o: 5};
        tab[1] = '{lo_v: 15, hi_v: 15, pmode: 0, exp_e: 0, exp_o: 1};
        tab[2] = '{lo_v: 9,  hi_v: 3,  pmode: 0, exp_e: 0, exp_o: 1};
        tab[3] = '{lo_v: 0,  hi_v: 15, pmode: 1, exp_e: 8, exp_o: 8};
        tab[4] = '{lo_v: 2,  hi_v: 5,  pmode: 0, exp_e: 2, exp_o: 2};
        tab[5] = '{lo_v: 1,  hi_v: 14, pmode: 1, exp_e: 7, exp_o: 7};

        #2;
        chk("rst_busy", busy, 0);
        chk("rst_cur_val", cur_val, 0);
        chk("rst_valid", cur_valid, 0);
        chk("rst_even_cnt", even_cnt, 0);
        chk("rst_odd_cnt", odd_cnt, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++)
            run_sweep(tab[i].lo_v, tab[i].hi_v, tab[i].pmode, tab[i].exp_e, tab[i].exp_o, 1'b1);

        for (int i = 0; i < 15; i++)
            run_sweep(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 2, 0, 0, 1'b0);

        // Reset mid-sweep: abort at cur_val == 4, expect everything cleared and no done.
        @(negedge clk);
        lo = 4'd0;
        hi = 4'd10;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (cur_val != 4'd4 && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        chk("reach_val4", cur_val, 4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_cur_val", cur_val, 0);
        chk("arst_valid", cur_valid, 0);
        chk("arst_even_cnt", even_cnt, 0);
        chk("arst_odd_cnt", odd_cnt, 0);
        chk("arst_done", done, 0);
        chk("arst_err", err, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("arst_hold_done", done, 0);
            chk("arst_hold_busy", busy, 0);
        end
        rst_n = 1'b1;
        m_even = 0;
        m_odd = 0;
        run_sweep(0, 10, 0, 6, 5, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
